// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver: 2-flop synchroniser, 3-sample majority vote, mid-bit sampling, stop-bit check.
// Define UART_RX_PARITY_EN to receive 8E1 frames and enable the parity_err output.
module uart_rx_oversample #(
  parameter int CLK_FREQ = 1000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] doutrx,
  output logic       donerx,
  output logic       frame_err,
  output logic       rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int B    = CLK_FREQ / BAUD;
  localparam int HALF = B / 2;
  localparam int CW   = $clog2(B);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(B - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state_reg;
  logic [1:0]    sync_reg;
  logic [2:0]    hist_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    data_reg;
  logic          rs;
  logic          vote;
`ifdef UART_RX_PARITY_EN
  logic          par_reg;
`endif

  assign rs   = sync_reg[1];
  assign vote = (hist_reg[0] & hist_reg[1]) | (hist_reg[0] & hist_reg[2]) |
                (hist_reg[1] & hist_reg[2]);

  // Synchroniser and vote history idle high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b11;
      hist_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[0], rx};
      hist_reg <= {hist_reg[1:0], rs};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      data_reg   <= '0;
      doutrx     <= '0;
      donerx     <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_reg    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      donerx    <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (hist_reg[0] && !rs) begin
            state_reg <= START;
            cnt_reg   <= '0;
            rx_busy   <= 1'b1;
          end
        end
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            bit_reg <= '0;
            if (vote) begin
              state_reg <= IDLE;
              rx_busy   <= 1'b0;
            end else begin
              state_reg <= DATA;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg  <= '0;
            data_reg <= {vote, data_reg[7:1]};
            if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg   <= '0;
            par_reg   <= vote;
            state_reg <= STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (vote) begin
              // Returning to IDLE at mid-stop-bit leaves room to catch a back-to-back start edge.
              doutrx    <= data_reg;
              donerx    <= 1'b1;
              state_reg <= IDLE;
              rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
              parity_err <= ^{data_reg, par_reg};
`endif
            end else begin
              frame_err <= 1'b1;
              state_reg <= WAIT_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) must return high before a new start edge is accepted.
          if (rs) begin
            state_reg <= IDLE;
            rx_busy   <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          rx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
